// File: rtl/sti4_sbox_sched_if.sv
// Bus bundle for sti4_sbox_sched: start/state-share handshake plus the S-box core link.
// Define STI4_REMASK_EN to add the rnd input used to re-mask captured core outputs.
interface sti4_sbox_sched_if #(parameter int NIB = 16);
   logic               start;
   logic [4*NIB-1:0]   st_in0;
   logic [4*NIB-1:0]   st_in1;
   logic [4*NIB-1:0]   st_in2;
   logic               busy;
   logic               done;
   logic [4*NIB-1:0]   st_out0;
   logic [4*NIB-1:0]   st_out1;
   logic [4*NIB-1:0]   st_out2;
   logic [3:0]         sb_x0;
   logic [3:0]         sb_x1;
   logic [3:0]         sb_x2;
   logic               sb_vld;
   logic [3:0]         sb_y0;
   logic [3:0]         sb_y1;
   logic [3:0]         sb_y2;
`ifdef STI4_REMASK_EN
   logic [7:0]         rnd;

   modport master (
      output start, st_in0, st_in1, st_in2, sb_y0, sb_y1, sb_y2, rnd,
      input  busy, done, st_out0, st_out1, st_out2, sb_x0, sb_x1, sb_x2, sb_vld
   );
   modport slave (
      input  start, st_in0, st_in1, st_in2, sb_y0, sb_y1, sb_y2, rnd,
      output busy, done, st_out0, st_out1, st_out2, sb_x0, sb_x1, sb_x2, sb_vld
   );
`else
   modport master (
      output start, st_in0, st_in1, st_in2, sb_y0, sb_y1, sb_y2,
      input  busy, done, st_out0, st_out1, st_out2, sb_x0, sb_x1, sb_x2, sb_vld
   );
   modport slave (
      input  start, st_in0, st_in1, st_in2, sb_y0, sb_y1, sb_y2,
      output busy, done, st_out0, st_out1, st_out2, sb_x0, sb_x1, sb_x2, sb_vld
   );
`endif
endinterface

// File: rtl/sti4_sbox_sched.sv
// Time-shares one pipelined 3-share TI 4-bit S-box core across all nibbles of the state.
// STI4_REMASK_EN: re-mask each captured nibble with fresh rnd (unshared value unchanged).
//
// state | meaning
// IDLE  | waiting for start; busy=0
// ISSUE | one nibble per cycle presented to the core (sb_vld=1)
// DRAIN | waiting for the last core results to return
module sti4_sbox_sched #(
   parameter int NIB = 16,
   parameter int LAT = 2
) (
   input logic              clk,
   input logic              rst,
   sti4_sbox_sched_if.slave bus
);
   localparam int CW = $clog2(NIB) + 1;
   localparam int W  = 4 * NIB;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   wk0, wk1, wk2;
   logic [W-1:0]   res0, res1, res2;
   logic [W-1:0]   res0_nxt, res1_nxt, res2_nxt;
   logic [W-1:0]   out0, out1, out2;
   logic [CW-1:0]  issue_cnt, wb_cnt;
   logic [LAT-1:0] vpipe;
   logic [3:0]     x0_q, x1_q, x2_q;
   logic [3:0]     y0, y1, y2;
   logic           done_q;
   logic           busy_c, vld_c;
   logic           accept, cap, last_cap, issue_more;

   assign accept     = (state == IDLE) && bus.start;
   assign cap        = vpipe[LAT-1];
   assign last_cap   = cap && (wb_cnt == CW'(NIB - 1));
   assign issue_more = (state == ISSUE) && (issue_cnt != CW'(NIB));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b1;
      vld_c     = 1'b0;
      case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_nxt = ISSUE;
         end
         ISSUE: begin
            vld_c = 1'b1;
            if (issue_cnt == CW'(NIB)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (last_cap) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // sb_x is registered per share; issue_cnt indexes the nibble loaded next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wk0       <= '0;
         wk1       <= '0;
         wk2       <= '0;
         x0_q      <= '0;
         x1_q      <= '0;
         x2_q      <= '0;
         issue_cnt <= '0;
      end else if (accept) begin
         wk0       <= bus.st_in0;
         wk1       <= bus.st_in1;
         wk2       <= bus.st_in2;
         x0_q      <= bus.st_in0[3:0];
         x1_q      <= bus.st_in1[3:0];
         x2_q      <= bus.st_in2[3:0];
         issue_cnt <= CW'(1);
      end else if (issue_more) begin
         x0_q      <= wk0[{issue_cnt[CW-2:0], 2'b00} +: 4];
         x1_q      <= wk1[{issue_cnt[CW-2:0], 2'b00} +: 4];
         x2_q      <= wk2[{issue_cnt[CW-2:0], 2'b00} +: 4];
         issue_cnt <= issue_cnt + CW'(1);
      end else begin
         x0_q      <= '0;
         x1_q      <= '0;
         x2_q      <= '0;
      end
   end

   always_comb begin
`ifdef STI4_REMASK_EN
      y0 = bus.sb_y0 ^ bus.rnd[3:0];
      y1 = bus.sb_y1 ^ bus.rnd[7:4];
      y2 = bus.sb_y2 ^ bus.rnd[3:0] ^ bus.rnd[7:4];
`else
      y0 = bus.sb_y0;
      y1 = bus.sb_y1;
      y2 = bus.sb_y2;
`endif
      res0_nxt = res0;
      res1_nxt = res1;
      res2_nxt = res2;
      if (cap) begin
         res0_nxt[{wb_cnt[CW-2:0], 2'b00} +: 4] = y0;
         res1_nxt[{wb_cnt[CW-2:0], 2'b00} +: 4] = y1;
         res2_nxt[{wb_cnt[CW-2:0], 2'b00} +: 4] = y2;
      end
   end

   // Clearing vpipe on reset is what discards results still inside the core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe  <= '0;
         wb_cnt <= '0;
         res0   <= '0;
         res1   <= '0;
         res2   <= '0;
         out0   <= '0;
         out1   <= '0;
         out2   <= '0;
         done_q <= 1'b0;
      end else begin
         vpipe  <= (vpipe << 1) | LAT'(vld_c);
         done_q <= last_cap;
         if (accept)   wb_cnt <= '0;
         else if (cap) wb_cnt <= wb_cnt + CW'(1);
         if (cap) begin
            res0 <= res0_nxt;
            res1 <= res1_nxt;
            res2 <= res2_nxt;
         end
         if (last_cap) begin
            out0 <= res0_nxt;
            out1 <= res1_nxt;
            out2 <= res2_nxt;
         end
      end
   end

   assign bus.busy    = busy_c;
   assign bus.sb_vld  = vld_c;
   assign bus.done    = done_q;
   assign bus.sb_x0   = x0_q;
   assign bus.sb_x1   = x1_q;
   assign bus.sb_x2   = x2_q;
   assign bus.st_out0 = out0;
   assign bus.st_out1 = out1;
   assign bus.st_out2 = out2;
endmodule

// File: tb/tb_sti4_sbox_sched.sv
// Bench for sti4_sbox_sched: random-mask TI core model, cycle-level reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_sti4_sbox_sched;
   localparam int NIB = 16;
   localparam int LAT = 2;
   localparam int W   = 4 * NIB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sti4_sbox_sched_if #(.NIB(NIB)) ifc ();
   sti4_sbox_sched #(.NIB(NIB), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(ifc));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] s4(input logic [3:0] v);
      case (v)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   // External core: S on the unshared nibble, re-shared with fresh masks, LAT cycles later.
   logic [3:0]  py0 [LAT];
   logic [3:0]  py1 [LAT];
   logic [3:0]  py2 [LAT];
   logic [11:0] ycap [$];
   always @(posedge clk) begin
      logic [3:0] s, m1, m2;
      s  = s4(ifc.sb_x0 ^ ifc.sb_x1 ^ ifc.sb_x2);
      m1 = 4'($urandom);
      m2 = 4'($urandom);
      if (!ifc.sb_vld) begin
         s = 4'h0; m1 = 4'h0; m2 = 4'h0;
      end else begin
         ycap.push_back({s ^ m1 ^ m2, m1, m2});
      end
      for (int i = LAT - 1; i > 0; i--) begin
         py0[i] <= py0[i-1];
         py1[i] <= py1[i-1];
         py2[i] <= py2[i-1];
      end
      py0[0] <= s ^ m1 ^ m2;
      py1[0] <= m1;
      py2[0] <= m2;
   end
   assign ifc.sb_y0 = py0[LAT-1];
   assign ifc.sb_y1 = py1[LAT-1];
   assign ifc.sb_y2 = py2[LAT-1];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Pins set by the stimulus: 1 = single op with known unshared result, 2 = held start.
   int           pin_mode = 0;
   int           pin_t0 = 0;
   bit           pin_x = 0;
   logic [W-1:0] pin_val = '0;

   bit           act = 0;
   int           k = 0;
   int           ybase = 0;
   logic [W-1:0] w0, w1, w2;
   logic [W-1:0] eo0 = '0, eo1 = '0, eo2 = '0;

   always @(negedge clk) begin
      int         c, idx, rel;
      bit         e_busy, e_vld, e_done;
      logic [11:0] ex, y;
      logic [3:0] rlo, rhi;
      c = cyc;
`ifdef STI4_REMASK_EN
      rlo = ifc.rnd[3:0];
      rhi = ifc.rnd[7:4];
`else
      rlo = 4'h0;
      rhi = 4'h0;
`endif
      if (rst) begin
         act = 0;
         eo0 = '0; eo1 = '0; eo2 = '0;
         chk("rst_busy", 64'(ifc.busy), 64'd0);
         chk("rst_done", 64'(ifc.done), 64'd0);
         chk("rst_vld", 64'(ifc.sb_vld), 64'd0);
         chk("rst_sbx", 64'({ifc.sb_x0, ifc.sb_x1, ifc.sb_x2}), 64'd0);
         chk("rst_out", 64'(ifc.st_out0 | ifc.st_out1 | ifc.st_out2), 64'd0);
      end else begin
         e_busy = act && c >= k + 1 && c <= k + NIB + LAT;
         e_vld  = act && c >= k + 1 && c <= k + NIB;
         e_done = act && c == k + NIB + LAT + 1;
         ex = '0;
         if (e_vld) begin
            idx = c - k - 1;
            ex  = {w0[4*idx +: 4], w1[4*idx +: 4], w2[4*idx +: 4]};
         end
         if (e_done) begin
            chk("core_results", 64'(ycap.size() - ybase), 64'(NIB));
            if (ycap.size() >= ybase + NIB) begin
               for (int i = 0; i < NIB; i++) begin
                  y = ycap[ybase + i];
                  eo0[4*i +: 4] = y[11:8] ^ rlo;
                  eo1[4*i +: 4] = y[7:4] ^ rhi;
                  eo2[4*i +: 4] = y[3:0] ^ rlo ^ rhi;
               end
            end
         end
         chk("busy", 64'(ifc.busy), 64'(e_busy));
         chk("done", 64'(ifc.done), 64'(e_done));
         chk("sb_vld", 64'(ifc.sb_vld), 64'(e_vld));
         chk("sb_x", 64'({ifc.sb_x0, ifc.sb_x1, ifc.sb_x2}), 64'(ex));
         chk("st_out0", ifc.st_out0, eo0);
         chk("st_out1", ifc.st_out1, eo1);
         chk("st_out2", ifc.st_out2, eo2);
         rel = c - pin_t0;
         if (ifc.done && pin_mode == 1) begin
            chk("pin_latency", 64'(rel), 64'd19);
            chk("pin_unshared", ifc.st_out0 ^ ifc.st_out1 ^ ifc.st_out2, pin_val);
         end
         if (ifc.done && pin_mode == 2)
            chk("pin_held_done", 64'(rel == 19 || rel == 38 || rel == 57), 64'd1);
         if (pin_mode == 1 && pin_x && rel >= 1 && rel <= NIB)
            chk("pin_sbx0", 64'(ifc.sb_x0), 64'(4'hF - 4'(rel - 1)));
         if (ifc.start && !e_busy) begin
            act = 1;
            k = c;
            w0 = ifc.st_in0; w1 = ifc.st_in1; w2 = ifc.st_in2;
            ybase = ycap.size();
         end
      end
   end

   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d,
                     input int mode, input logic [W-1:0] pv, input bit px, input int hold);
      @(posedge clk);
      #1;
      ifc.st_in0 = a;
      ifc.st_in1 = b;
      ifc.st_in2 = d;
      ifc.start  = 1'b1;
      pin_mode   = mode;
      pin_t0     = cyc;
      pin_val    = pv;
      pin_x      = px;
      repeat (hold) @(posedge clk);
      #1 ifc.start = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   localparam logic [W-1:0] NOM_IN  = 64'h0123456789ABCDEF;
   localparam logic [W-1:0] NOM_OUT = 64'hC56B90AD3EF84712;
   localparam logic [W-1:0] RS_IN   = 64'hFEDCBA9876543210;
   localparam logic [W-1:0] RS_OUT  = 64'h21748FE3DA09B65C;

   initial begin
      logic [W-1:0] b, d;
      ifc.start  = 1'b0;
      ifc.st_in0 = '0;
      ifc.st_in1 = '0;
      ifc.st_in2 = '0;
`ifdef STI4_REMASK_EN
      ifc.rnd = 8'hA5;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      go(NOM_IN, '0, '0, 1, NOM_OUT, 1'b1, 1);
      repeat (24) @(posedge clk);

      b = rnd64();
      d = rnd64();
      go(RS_IN ^ b ^ d, b, d, 1, RS_OUT, 1'b0, 1);
      repeat (24) @(posedge clk);

      b = rnd64();
      d = rnd64();
      go(RS_IN ^ b ^ d, b, d, 2, '0, 1'b0, 40);
      repeat (25) @(posedge clk);

      go(NOM_IN, '0, '0, 0, '0, 1'b0, 1);
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      b = rnd64();
      d = rnd64();
      go(NOM_IN ^ b ^ d, b, d, 1, NOM_OUT, 1'b0, 1);
      repeat (24) @(posedge clk);

      for (int n = 0; n < 10; n++) begin
         go(rnd64(), rnd64(), rnd64(), 0, '0, 1'b0, $urandom_range(1, 3));
         repeat ($urandom_range(0, 25)) @(posedge clk);
      end
      repeat (30) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
